// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register: drives the data-memory req/ready port, stalls
// the front of the pipe while an access is outstanding, and aborts hung accesses.
module mem_wb_stage #(
   parameter int DATA_W  = 32,
   parameter int WR_W    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              MemWriteIn,
   input  logic              MemReadIn,
   input  logic              MemToRegIn,
   input  logic              RegWriteIn,
   input  logic [WR_W-1:0]   WriteRegisterIn,
   input  logic [DATA_W-1:0] ALUResultIn,
   input  logic [DATA_W-1:0] WriteDataIn,
   output logic              DMemReq,
   output logic              DMemWe,
   output logic [DATA_W-1:0] DMemAddr,
   output logic [DATA_W-1:0] DMemWData,
   input  logic              DMemReady,
   input  logic [DATA_W-1:0] DMemRData,
   output logic              StallOut,
   output logic              RegWriteOut,
   output logic              MemToRegOut,
   output logic [WR_W-1:0]   WriteRegisterOut,
   output logic [DATA_W-1:0] ALUResultOut,
   output logic [DATA_W-1:0] ReadDataOut,
   output logic              BusErrorOut,
   output logic              state_dbg
);

   localparam int CW = $clog2(TIMEOUT + 1);

   // Handshake: a transfer happens only on an edge with DMemReq=1 and DMemReady=1;
   // DMemReady is ignored while DMemReq=0; we/addr/wdata never change while DMemReq=1.
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              mem_op, timed_out, latch_op;

   logic              hold_we, hold_rw, hold_m2r;
   logic [WR_W-1:0]   hold_wr;
   logic [DATA_W-1:0] hold_addr, hold_wdata, hold_alu;

   logic              nxt_rw, nxt_m2r;
   logic [WR_W-1:0]   nxt_wr;
   logic [DATA_W-1:0] nxt_alu, nxt_rd;

   assign mem_op    = MemReadIn | MemWriteIn;
   assign state_dbg = state;

   always_comb begin
      state_nxt = state;
      DMemReq   = 1'b0;
      DMemWe    = 1'b0;
      DMemAddr  = '0;
      DMemWData = '0;
      StallOut  = 1'b0;
      timed_out = 1'b0;
      latch_op  = 1'b0;
      nxt_rw    = 1'b0;
      nxt_m2r   = 1'b0;
      nxt_wr    = '0;
      nxt_alu   = '0;
      nxt_rd    = '0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               DMemReq   = 1'b1;
               DMemWe    = MemWriteIn;
               DMemAddr  = ALUResultIn;
               DMemWData = WriteDataIn;
               StallOut  = !DMemReady;
            end
            if (!mem_op || DMemReady) begin
               nxt_rw  = RegWriteIn;
               nxt_m2r = MemToRegIn;
               nxt_wr  = WriteRegisterIn;
               nxt_alu = ALUResultIn;
               // a simultaneous read+write is a write, so no load data
               nxt_rd  = (mem_op && !MemWriteIn) ? DMemRData : '0;
            end else begin
               latch_op  = 1'b1;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            DMemReq   = 1'b1;
            DMemWe    = hold_we;
            DMemAddr  = hold_addr;
            DMemWData = hold_wdata;
            timed_out = !DMemReady && (cnt == CW'(TIMEOUT));
            // released on the abort cycle too, so the faulting instruction is dropped
            StallOut  = !DMemReady && !timed_out;
            if (DMemReady) begin
               nxt_rw    = hold_rw;
               nxt_m2r   = hold_m2r;
               nxt_wr    = hold_wr;
               nxt_alu   = hold_alu;
               nxt_rd    = hold_we ? '0 : DMemRData;
               state_nxt = IDLE;
            end else if (timed_out) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (Reset) begin
         DMemReq   = 1'b0;
         StallOut  = 1'b0;
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state            <= IDLE;
         cnt              <= '0;
         hold_we          <= 1'b0;
         hold_rw          <= 1'b0;
         hold_m2r         <= 1'b0;
         hold_wr          <= '0;
         hold_addr        <= '0;
         hold_wdata       <= '0;
         hold_alu         <= '0;
         RegWriteOut      <= 1'b0;
         MemToRegOut      <= 1'b0;
         WriteRegisterOut <= '0;
         ALUResultOut     <= '0;
         ReadDataOut      <= '0;
         BusErrorOut      <= 1'b0;
      end else begin
         state            <= state_nxt;
         RegWriteOut      <= nxt_rw;
         MemToRegOut      <= nxt_m2r;
         WriteRegisterOut <= nxt_wr;
         ALUResultOut     <= nxt_alu;
         ReadDataOut      <= nxt_rd;
         if (latch_op) begin
            hold_we    <= MemWriteIn;
            hold_rw    <= RegWriteIn;
            hold_m2r   <= MemToRegIn;
            hold_wr    <= WriteRegisterIn;
            hold_addr  <= ALUResultIn;
            hold_wdata <= WriteDataIn;
            hold_alu   <= ALUResultIn;
            cnt        <= CW'(1);
         end else if (state == WAIT) begin
            if (DMemReady || timed_out) cnt <= '0;
            else                        cnt <= cnt + CW'(1);
         end
         if (timed_out) BusErrorOut <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vectors; combinational port checks before each edge,
// MEM/WB register checks by a scoreboard monitor after each edge.
module tb_mem_wb_stage;

   localparam int DATA_W = 32;
   localparam int WR_W   = 5;
   localparam int TMO    = 4;
   localparam int EW     = 1 + 1 + WR_W + DATA_W + DATA_W + 1 + 1;

   logic              Clock = 1'b0;
   logic              Reset;
   logic              MemWriteIn, MemReadIn, MemToRegIn, RegWriteIn;
   logic [WR_W-1:0]   WriteRegisterIn;
   logic [DATA_W-1:0] ALUResultIn, WriteDataIn;
   logic              DMemReq, DMemWe;
   logic [DATA_W-1:0] DMemAddr, DMemWData;
   logic              DMemReady;
   logic [DATA_W-1:0] DMemRData;
   logic              StallOut, RegWriteOut, MemToRegOut;
   logic [WR_W-1:0]   WriteRegisterOut;
   logic [DATA_W-1:0] ALUResultOut, ReadDataOut;
   logic              BusErrorOut, state_dbg;

   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_stage #(.DATA_W(DATA_W), .WR_W(WR_W), .TIMEOUT(TMO)) dut (
      .Clock(Clock), .Reset(Reset),
      .MemWriteIn(MemWriteIn), .MemReadIn(MemReadIn), .MemToRegIn(MemToRegIn),
      .RegWriteIn(RegWriteIn), .WriteRegisterIn(WriteRegisterIn),
      .ALUResultIn(ALUResultIn), .WriteDataIn(WriteDataIn),
      .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
      .DMemReady(DMemReady), .DMemRData(DMemRData),
      .StallOut(StallOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
      .WriteRegisterOut(WriteRegisterOut), .ALUResultOut(ALUResultOut),
      .ReadDataOut(ReadDataOut), .BusErrorOut(BusErrorOut), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 Clock = ~Clock;

   function automatic logic [EW-1:0] mw(input logic rw, input logic m2r, input logic [WR_W-1:0] wr,
                                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rd,
                                        input logic berr, input logic st);
      return {rw, m2r, wr, alu, rd, berr, st};
   endfunction

   function automatic logic [EW-1:0] bubble(input logic berr, input logic st);
      return mw(1'b0, 1'b0, '0, '0, '0, berr, st);
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_in();
      MemWriteIn = 0; MemReadIn = 0; MemToRegIn = 0; RegWriteIn = 0;
      WriteRegisterIn = '0; ALUResultIn = '0; WriteDataIn = '0;
      DMemReady = 0; DMemRData = '0;
   endtask

   // driver: inputs are already applied; check combinational ports, queue MEM/WB expectation
   task automatic tick(input logic e_stall, input logic e_req, input logic e_we,
                       input logic [DATA_W-1:0] e_addr, input logic [DATA_W-1:0] e_wdata,
                       input logic [EW-1:0] e_mw);
      #1;
      chk("stall", {31'd0, StallOut}, {31'd0, e_stall});
      chk("req", {31'd0, DMemReq}, {31'd0, e_req});
      if (e_req) begin
         chk("we", {31'd0, DMemWe}, {31'd0, e_we});
         chk("addr", DMemAddr, e_addr);
         if (e_we) chk("wdata", DMemWData, e_wdata);
      end
      exp_q.push_back(e_mw);
      @(negedge Clock);
   endtask

   // scoreboard monitor
   always @(posedge Clock) begin
      logic [EW-1:0] e, a;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {RegWriteOut, MemToRegOut, WriteRegisterOut, ALUResultOut, ReadDataOut,
              BusErrorOut, state_dbg};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL mem_wb: actual %h required %h at %0t", a, e, $time);
         end
      end
   end

   initial begin
      clear_in();
      Reset = 1;
      @(negedge Clock);
      // 1: reset, then idle
      tick(0, 0, 0, 0, 0, bubble(0, 0));
      tick(0, 0, 0, 0, 0, bubble(0, 0));
      Reset = 0;
      tick(0, 0, 0, 0, 0, bubble(0, 0));

      // 2: ALU op; a stray DMemReady with no request is ignored
      RegWriteIn = 1; WriteRegisterIn = 9; ALUResultIn = 32'h1234;
      DMemReady = 1; DMemRData = 32'h77;
      tick(0, 0, 0, 0, 0, mw(1, 0, 9, 32'h1234, 0, 0, 0));

      // 3: zero-wait load
      clear_in();
      MemReadIn = 1; MemToRegIn = 1; RegWriteIn = 1; WriteRegisterIn = 3; ALUResultIn = 32'h40;
      DMemReady = 1; DMemRData = 32'hDEADBEEF;
      tick(0, 1, 0, 32'h40, 0, mw(1, 1, 3, 32'h40, 32'hDEADBEEF, 0, 0));

      // 4: load with 3 stall cycles; live inputs disturbed to prove the hold copy is used
      clear_in();
      MemReadIn = 1; MemToRegIn = 1; RegWriteIn = 1; WriteRegisterIn = 4; ALUResultIn = 32'h80;
      tick(1, 1, 0, 32'h80, 0, bubble(0, 1));
      ALUResultIn = 32'hFFFF0000; WriteRegisterIn = 17;
      tick(1, 1, 0, 32'h80, 0, bubble(0, 1));
      tick(1, 1, 0, 32'h80, 0, bubble(0, 1));
      DMemReady = 1; DMemRData = 32'hA5A5A5A5;
      tick(0, 1, 0, 32'h80, 0, mw(1, 1, 4, 32'h80, 32'hA5A5A5A5, 0, 0));
      WriteRegisterIn = 5; ALUResultIn = 32'h84; DMemRData = 32'h11112222;
      tick(0, 1, 0, 32'h84, 0, mw(1, 1, 5, 32'h84, 32'h11112222, 0, 0));

      // 5: store with 2 wait cycles
      clear_in();
      MemWriteIn = 1; WriteRegisterIn = 7; ALUResultIn = 32'h10; WriteDataIn = 32'hCAFEF00D;
      tick(1, 1, 1, 32'h10, 32'hCAFEF00D, bubble(0, 1));
      WriteDataIn = 32'h0;
      tick(1, 1, 1, 32'h10, 32'hCAFEF00D, bubble(0, 1));
      DMemReady = 1; DMemRData = 32'h99999999;
      tick(0, 1, 1, 32'h10, 32'hCAFEF00D, mw(0, 0, 7, 32'h10, 0, 0, 0));

      // read+write together is a write: no load data
      clear_in();
      MemReadIn = 1; MemWriteIn = 1; RegWriteIn = 1; WriteRegisterIn = 8;
      ALUResultIn = 32'h20; WriteDataIn = 32'h55; DMemReady = 1; DMemRData = 32'h12345678;
      tick(0, 1, 1, 32'h20, 32'h55, mw(1, 0, 8, 32'h20, 0, 0, 0));

      // ready arrives on the timeout cycle: ready wins, no error
      clear_in();
      MemReadIn = 1; RegWriteIn = 1; WriteRegisterIn = 10; ALUResultIn = 32'h30;
      tick(1, 1, 0, 32'h30, 0, bubble(0, 1));
      for (int i = 0; i < TMO - 1; i++) tick(1, 1, 0, 32'h30, 0, bubble(0, 1));
      DMemReady = 1; DMemRData = 32'h0BADF00D;
      tick(0, 1, 0, 32'h30, 0, mw(1, 0, 10, 32'h30, 32'h0BADF00D, 0, 0));

      // 6: timeout abort, sticky error, then normal ALU op
      clear_in();
      MemReadIn = 1; RegWriteIn = 1; WriteRegisterIn = 6; ALUResultIn = 32'h60;
      tick(1, 1, 0, 32'h60, 0, bubble(0, 1));
      for (int i = 0; i < TMO - 1; i++) tick(1, 1, 0, 32'h60, 0, bubble(0, 1));
      tick(0, 1, 0, 32'h60, 0, bubble(1, 0));
      clear_in();
      RegWriteIn = 1; WriteRegisterIn = 2; ALUResultIn = 32'h55;
      tick(0, 0, 0, 0, 0, mw(1, 0, 2, 32'h55, 0, 1, 0));

      // reset mid-WAIT abandons the access and clears the error
      clear_in();
      MemReadIn = 1; RegWriteIn = 1; WriteRegisterIn = 11; ALUResultIn = 32'h70;
      tick(1, 1, 0, 32'h70, 0, bubble(1, 1));
      Reset = 1;
      tick(0, 0, 0, 0, 0, bubble(0, 0));
      Reset = 0;
      clear_in();
      tick(0, 0, 0, 0, 0, bubble(0, 0));

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge Clock);
      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
